ctrl_seq: RTL

CTRL_SEQ -- requirements
Module: ctrl_seq

---
 rtl/ctrl_seq_pkg.sv | 29 ++
 rtl/mem_wdog.sv | 58 +++++
 rtl/ctrl_seq.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ctrl_seq_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_seq_pkg
// Shared ops header for the control sequencer: one-hot state encodings,
// memory opcodes, the watchdog counter width and an opcode classifier.
// ----------------------------------------------------------------------------
package ctrl_seq_pkg;

  localparam int STATE_W = 7;

  localparam logic [STATE_W-1:0] ST_FETCH   = 7'b0000001;
  localparam logic [STATE_W-1:0] ST_DECODE  = 7'b0000010;
  localparam logic [STATE_W-1:0] ST_REGREAD = 7'b0000100;
  localparam logic [STATE_W-1:0] ST_EXECUTE = 7'b0001000;
  localparam logic [STATE_W-1:0] ST_MEM     = 7'b0010000;
  localparam logic [STATE_W-1:0] ST_WB      = 7'b0100000;
  localparam logic [STATE_W-1:0] ST_FAULT   = 7'b1000000;

  localparam logic [3:0] OPC_READ  = 4'h8;
  localparam logic [3:0] OPC_WRITE = 4'h9;

  // Wide enough for the largest legal timeout (255).
  localparam int WDOG_CNT_W = 8;

  // Opcodes that need a data-memory access after EXECUTE.
  function automatic logic is_mem_op(input logic [3:0] opc);
    return (opc == OPC_READ) || (opc == OPC_WRITE);
  endfunction

endpackage

// File: rtl/mem_wdog.sv
// ----------------------------------------------------------------------------
// mem_wdog
// Tracks one outstanding memory request: holds the wait flag and counts wait
// cycles starting at 1 in the first cycle after the request. A completion
// ends the wait; reaching TIMEOUT without completion raises expired (the
// completion wins if both happen in the same cycle).
//
// Ports
//   clk      in   clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   start    in   request issued this cycle; begin waiting
//   done     in   completion seen this cycle (ignored when not waiting)
//   clear    in   abandon the wait (fault recovery)
//   waiting  out  a request is outstanding
//   expired  out  wait limit hit in this cycle with no completion
// ----------------------------------------------------------------------------
module mem_wdog
  import ctrl_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic done,
  input  logic clear,
  output logic waiting,
  output logic expired
);

  localparam logic [WDOG_CNT_W-1:0] LIMIT = WDOG_CNT_W'(TIMEOUT);

  logic [WDOG_CNT_W-1:0] count;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the values that existed before the clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      waiting <= 1'b0;
      count   <= '0;
    end else if (clear) begin
      waiting <= 1'b0;
      count   <= '0;
    end else if (start) begin
      waiting <= 1'b1;
      count   <= WDOG_CNT_W'(1);
    end else if (waiting && done) begin
      waiting <= 1'b0;
      count   <= '0;
    end else if (waiting && (count != LIMIT)) begin
      // Saturates at LIMIT so expired stays asserted until cleared.
      count <= count + WDOG_CNT_W'(1);
    end
  end

  assign expired = waiting && (count == LIMIT) && !done;

endmodule

// File: rtl/ctrl_seq.sv
// ----------------------------------------------------------------------------
// ctrl_seq
// Multi-cycle instruction control sequencer:
//   FETCH -> DECODE -> REGREAD -> EXECUTE -> (MEM) -> WB -> FETCH
// with a memory-timeout FAULT state. Memory requests are registered
// one-cycle pulses; the wait for completion is tracked by mem_wdog.
//
// Ports
//   clk            in   clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   I_instruction  in   memory read data captured during FETCH
//   I_mem_ready    in   memory can accept a request
//   I_data_ready   in   memory completion / acknowledge
//   I_stall        in   hold in DECODE, REGREAD, EXECUTE and WB
//   I_fault_clr    in   leave FAULT
//   O_state        out  one-hot state
//   O_ir           out  latched instruction
//   O_mem_req      out  one-cycle memory request pulse
//   O_mem_we       out  request is a write (valid with O_mem_req)
//   O_reg_we       out  register-file write enable
//   O_fault        out  memory timeout fault flag
// ----------------------------------------------------------------------------
module ctrl_seq
  import ctrl_seq_pkg::*;
#(
  parameter int INSTR_W     = 16,
  parameter int OPC_LSB     = 12,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [INSTR_W-1:0] I_instruction,
  input  logic               I_mem_ready,
  input  logic               I_data_ready,
  input  logic               I_stall,
  input  logic               I_fault_clr,
  output logic [6:0]         O_state,
  output logic [INSTR_W-1:0] O_ir,
  output logic               O_mem_req,
  output logic               O_mem_we,
  output logic               O_reg_we,
  output logic               O_fault
);

  logic [STATE_W-1:0] state;
  logic [3:0]         opc;
  logic               in_fetch;
  logic               in_mem;
  logic               is_write;
  logic               write_cycle;
  logic               waiting;
  logic               expired;
  logic               mem_done;
  logic               issue;
  logic               wd_start;
  logic               wd_clear;

  assign opc      = O_ir[OPC_LSB +: 4];
  assign in_fetch = (state == ST_FETCH);
  assign in_mem   = (state == ST_MEM);
  assign is_write = (opc == OPC_WRITE);

  // A store in MEM is fire-and-forget: it never arms the watchdog and
  // finishes the cycle after its request, regardless of I_data_ready.
  assign write_cycle = in_mem && is_write;

  // Completion only counts for an outstanding wait in a memory state.
  assign mem_done = waiting && I_data_ready && (in_fetch || in_mem);

  // The !O_mem_req term keeps a store from re-requesting while its own
  // pulse is still visible.
  assign issue    = (in_fetch || in_mem) && !waiting && !O_mem_req && I_mem_ready;
  assign wd_start = issue && !write_cycle;
  assign wd_clear = (state == ST_FAULT) && I_fault_clr;

  mem_wdog #(
    .TIMEOUT (MEM_TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (wd_start),
    .done    (mem_done),
    .clear   (wd_clear),
    .waiting (waiting),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_FETCH;
      O_ir      <= '0;
      O_mem_req <= 1'b0;
      O_mem_we  <= 1'b0;
    end else begin
      O_mem_req <= issue;
      O_mem_we  <= issue && write_cycle;

      case (state)
        ST_FETCH: begin
          if (mem_done) begin
            O_ir  <= I_instruction;
            state <= ST_DECODE;
          end else if (expired) begin
            state <= ST_FAULT;
          end
        end

        ST_DECODE: begin
          if (!I_stall) state <= ST_REGREAD;
        end

        ST_REGREAD: begin
          if (!I_stall) state <= ST_EXECUTE;
        end

        ST_EXECUTE: begin
          if (!I_stall) state <= is_mem_op(opc) ? ST_MEM : ST_WB;
        end

        ST_MEM: begin
          if (write_cycle) begin
            if (O_mem_req) state <= ST_WB;
          end else if (mem_done) begin
            state <= ST_WB;
          end else if (expired) begin
            state <= ST_FAULT;
          end
        end

        ST_WB: begin
          if (!I_stall) state <= ST_FETCH;
        end

        ST_FAULT: begin
          if (I_fault_clr) state <= ST_FETCH;
        end

        // NOTE: any code that is not a legal one-hot value recovers to FETCH
        // instead of locking up.
        default: state <= ST_FETCH;
      endcase
    end
  end

  assign O_state  = state;
  assign O_reg_we = (state == ST_WB) && !is_write;
  assign O_fault  = (state == ST_FAULT);

endmodule
